// File: rtl/iw_constant_encoder_if.sv
// Request/stream bundle for the IW move-wide constant encoder.
// Both channels use valid/ready: a transfer happens on a rising clock edge where valid && ready; the sender holds its payload stable while valid && !ready.
interface iw_constant_encoder_if;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_value;
  logic [4:0]  req_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_last;

  // Encoder side.
  modport slave (
    input  req_valid, req_value, req_rd, out_ready,
    output req_ready, out_valid, out_instr, out_last
  );

  // Requester / instruction consumer side.
  modport master (
    output req_valid, req_value, req_rd, out_ready,
    input  req_ready, out_valid, out_instr, out_last
  );
endinterface

// File: rtl/iw_constant_encoder.sv
// Streams the shortest MOVZ/MOVK sequence that loads a 64-bit constant into Rd,
// one 32-bit IW word per handshake, halfwords in ascending order.
module iw_constant_encoder #(
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  iw_constant_encoder_if.slave  bus,
  output logic                  busy,
  output logic                  state_dbg
);

  localparam logic [8:0] OP_MOVZ = 9'b110100101;
  localparam logic [8:0] OP_MOVK = 9'b111100101;

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t      state;
  logic [3:0]  mask_q;
  logic        first_q;
  logic [63:0] value_q;
  logic [4:0]  rd_q;
  logic [31:0] instr_q;
  logic        last_q;

  logic [3:0]  accept_mask;
  logic [3:0]  next_mask;

  function automatic logic [1:0] low_idx(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  function automatic logic one_hot(input logic [3:0] m);
    return (m != 4'b0000) && ((m & (m - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [15:0] halfword(input logic [63:0] v, input logic [1:0] n);
    logic [15:0] hw;
    case (n)
      2'd0:    hw = v[15:0];
      2'd1:    hw = v[31:16];
      2'd2:    hw = v[47:32];
      default: hw = v[63:48];
    endcase
    return hw;
  endfunction

  // Word for the lowest pending halfword of mask m; the first word is always MOVZ.
  function automatic logic [31:0] encode(input logic [63:0] v, input logic [4:0] rd,
                                         input logic [3:0] m, input logic first);
    logic [1:0] n;
    n = low_idx(m);
    return {(first ? OP_MOVZ : OP_MOVK), n, halfword(v, n), rd};
  endfunction

  always_comb begin
    accept_mask = 4'b1111;
    if (SKIP_ZERO != 0) begin
      for (int i = 0; i < 4; i++) begin
        accept_mask[i] = (halfword(bus.req_value, 2'(i)) != 16'h0000);
      end
      // An all-zero constant still needs one MOVZ to clear the register.
      if (accept_mask == 4'b0000) accept_mask = 4'b0001;
    end
  end

  assign next_mask = mask_q & ~(4'b0001 << low_idx(mask_q));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      mask_q  <= 4'b0000;
      first_q <= 1'b0;
      value_q <= 64'h0;
      rd_q    <= 5'd0;
      instr_q <= 32'h0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            state   <= EMIT;
            mask_q  <= accept_mask;
            first_q <= 1'b1;
            value_q <= bus.req_value;
            rd_q    <= bus.req_rd;
            instr_q <= encode(bus.req_value, bus.req_rd, accept_mask, 1'b1);
            last_q  <= one_hot(accept_mask);
          end
        end
        EMIT: begin
          if (bus.out_ready) begin
            mask_q  <= next_mask;
            first_q <= 1'b0;
            if (last_q) begin
              state   <= IDLE;
              instr_q <= 32'h0;
              last_q  <= 1'b0;
            end else begin
              instr_q <= encode(value_q, rd_q, next_mask, 1'b0);
              last_q  <= one_hot(next_mask);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.out_valid = (state == EMIT);
  assign bus.out_instr = instr_q;
  assign bus.out_last  = last_q;
  assign busy          = (state == EMIT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_iw_constant_encoder.sv
// Scoreboard bench for iw_constant_encoder: one instance with zero-halfword skipping,
// one emitting all four words, checked against a halfword-walking reference model.
module tb_iw_constant_encoder;

  localparam logic [8:0] MOVZ = 9'b110100101;
  localparam logic [8:0] MOVK = 9'b111100101;

  logic clock;
  logic reset;
  logic busy_a, busy_b;
  logic st_a, st_b;

  iw_constant_encoder_if ifa();
  iw_constant_encoder_if ifb();

  iw_constant_encoder #(.SKIP_ZERO(1)) dut_a (
    .clock(clock), .reset(reset), .bus(ifa), .busy(busy_a), .state_dbg(st_a)
  );
  iw_constant_encoder #(.SKIP_ZERO(0)) dut_b (
    .clock(clock), .reset(reset), .bus(ifb), .busy(busy_b), .state_dbg(st_b)
  );

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_a[$];
  logic [32:0] exp_b[$];
  bit rand_done;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: walk halfwords 0..3, keep nonzero ones (or all), first is MOVZ.
  task automatic push_model(input int sel, input logic [63:0] v, input logic [4:0] rd);
    int idx[$];
    logic [15:0] hw;
    for (int n = 0; n < 4; n++) begin
      hw = 16'(v >> (16 * n));
      if (sel == 1 || hw != 16'h0) idx.push_back(n);
    end
    if (idx.size() == 0) idx.push_back(0);
    for (int k = 0; k < idx.size(); k++) begin
      hw = 16'(v >> (16 * idx[k]));
      if (sel == 0)
        exp_a.push_back({(k == idx.size() - 1), (k == 0 ? MOVZ : MOVK), 2'(idx[k]), hw, rd});
      else
        exp_b.push_back({(k == idx.size() - 1), (k == 0 ? MOVZ : MOVK), 2'(idx[k]), hw, rd});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send(input int sel, input logic [63:0] v, input logic [4:0] rd);
    int t = 0;
    while (((sel == 0) ? !ifa.req_ready : !ifb.req_ready) && t < 200) begin
      @(posedge clock); #1; t++;
    end
    check_eq("req_ready_wait", t < 200, 1);
    if (sel == 0) begin
      ifa.req_valid = 1'b1; ifa.req_value = v; ifa.req_rd = rd;
    end else begin
      ifb.req_valid = 1'b1; ifb.req_value = v; ifb.req_rd = rd;
    end
    push_model(sel, v, rd);
    @(posedge clock); #1;
    if (sel == 0) begin
      ifa.req_valid = 1'b0; ifa.req_value = $urandom; ifa.req_rd = 5'($urandom);
      check_eq("latency_a", ifa.out_valid, 1);
    end else begin
      ifb.req_valid = 1'b0; ifb.req_value = $urandom; ifb.req_rd = 5'($urandom);
      check_eq("latency_b", ifb.out_valid, 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0 || busy_a || busy_b) && t < 400) begin
      @(posedge clock); #1; t++;
    end
    check_eq("drain_a_left", exp_a.size(), 0);
    check_eq("drain_b_left", exp_b.size(), 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  initial forever begin
    @(negedge clock);
    if (ifa.out_valid && ifa.out_ready) begin
      if (exp_a.size() == 0) check_eq("a_extra_word", {ifa.out_last, ifa.out_instr}, 33'h0);
      else check_eq("a_word", {ifa.out_last, ifa.out_instr}, exp_a.pop_front());
    end
  end

  initial forever begin
    @(negedge clock);
    if (ifb.out_valid && ifb.out_ready) begin
      if (exp_b.size() == 0) check_eq("b_extra_word", {ifb.out_last, ifb.out_instr}, 33'h0);
      else check_eq("b_word", {ifb.out_last, ifb.out_instr}, exp_b.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [63:0] v;
    reset = 1'b0;
    ifa.req_valid = 1'b0; ifa.req_value = 64'h0; ifa.req_rd = 5'd0; ifa.out_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_value = 64'h0; ifb.req_rd = 5'd0; ifb.out_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check_eq("rst_req_ready", ifa.req_ready, 1);
    check_eq("rst_out_valid", ifa.out_valid, 0);
    check_eq("rst_out_last", ifa.out_last, 0);
    check_eq("rst_out_instr", ifa.out_instr, 32'h0);
    check_eq("rst_busy", busy_a, 0);
    check_eq("rst_state", st_a, 0);
    @(negedge clock) reset = 1'b1;
    @(posedge clock); #1;

    // Single-word constant.
    send(0, 64'h0000_0000_0000_1234, 5'd5);
    check_eq("w_1234", ifa.out_instr, 32'hD2824685);
    check_eq("last_1234", ifa.out_last, 1);
    drain();

    // Two nonzero halfwords, bubble before next request.
    send(0, 64'hDEAD_0000_0000_BEEF, 5'd1);
    check_eq("w0_deadbeef", ifa.out_instr, 32'hD297DDE1);
    check_eq("rdy_emit0", ifa.req_ready, 0);
    @(posedge clock); #1;
    check_eq("w1_deadbeef", ifa.out_instr, 32'hF2FBD5A1);
    check_eq("last_deadbeef", ifa.out_last, 1);
    check_eq("rdy_emit1", ifa.req_ready, 0);
    @(posedge clock); #1;
    check_eq("rdy_after", ifa.req_ready, 1);
    check_eq("busy_after", busy_a, 0);
    drain();

    // All-zero and top-halfword-only constants.
    send(0, 64'h0, 5'd0);
    check_eq("w_zero", ifa.out_instr, 32'hD2800000);
    check_eq("last_zero", ifa.out_last, 1);
    drain();
    send(0, 64'h0001_0000_0000_0000, 5'd2);
    check_eq("w_hw3", ifa.out_instr, 32'hD2E00022);
    drain();

    // Four-word mode.
    send(1, 64'h0000_0000_0000_BEEF, 5'd1);
    check_eq("b_w0", ifb.out_instr, 32'hD297DDE1);
    check_eq("b_last0", ifb.out_last, 0);
    drain();

    // Backpressure on the first word plus a request attempt during EMIT.
    ifa.out_ready = 1'b0;
    send(0, 64'hDEAD_0000_0000_BEEF, 5'd1);
    ifa.req_valid = 1'b1; ifa.req_value = 64'h1234_5678_9ABC_DEF0; ifa.req_rd = 5'd9;
    repeat (3) begin
      check_eq("bp_instr", ifa.out_instr, 32'hD297DDE1);
      check_eq("bp_last", ifa.out_last, 0);
      check_eq("bp_rdy", ifa.req_ready, 0);
      @(posedge clock); #1;
    end
    check_eq("bp_instr_end", ifa.out_instr, 32'hD297DDE1);
    ifa.req_valid = 1'b0;
    ifa.out_ready = 1'b1;
    drain();

    // Asynchronous reset after the first handshake of a four-word sequence.
    send(0, 64'h1111_2222_3333_4444, 5'd3);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    check_eq("ar_out_valid", ifa.out_valid, 0);
    check_eq("ar_busy", busy_a, 0);
    check_eq("ar_req_ready", ifa.req_ready, 1);
    check_eq("ar_out_instr", ifa.out_instr, 32'h0);
    exp_a.delete();
    @(negedge clock) reset = 1'b1;
    send(0, 64'h0000_0000_00AB_0000, 5'd7);
    check_eq("ar_new_movz", ifa.out_instr, 32'hD2A01567);
    drain();

    // Random constants with random halfword zeroing and random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          v = {$urandom, $urandom};
          for (int n = 0; n < 4; n++)
            if ($urandom_range(0, 1) == 0) v = v & ~(64'hFFFF << (16 * n));
          send(i % 2, v, 5'($urandom_range(0, 31)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock); #1;
          ifa.out_ready = 1'($urandom_range(0, 1));
          ifb.out_ready = 1'($urandom_range(0, 1));
        end
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
